// File: rtl/incr_priority_arbiter.sv
// Fixed-priority arbiter for counter-increment requests sharing one datapath.
// Requests are edge-detected into pending latches, and one is granted per
// 12-cycle timepulse slot when the sequencer is not using the datapath.
module incr_priority_arbiter #(
  parameter int NREQ = 8,
  parameter int IDXW = 3,
  parameter int TMO  = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            busy,
  input  logic            ack,
  output logic            grant_vld,
  output logic [IDXW-1:0] grant_idx,
  output logic [NREQ-1:0] done,
  output logic [NREQ-1:0] pend,
  output logic [3:0]      tp,
  output logic            overrun,
  output logic            tmo_err
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    DONE
  } state_t;

  state_t          state;
  logic [NREQ-1:0] req_q;
  logic [NREQ-1:0] rise;
  logic [NREQ-1:0] clr;
  logic [IDXW-1:0] win_idx;
  logic [IDXW-1:0] idx_q;
  logic [7:0]      cnt;

  assign rise = req & ~req_q;

  // Lowest pending index wins; scanning downward lets index 0 override all others.
  always_comb begin
    win_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (pend[i]) win_idx = IDXW'(i);
    end
  end

  // The pending bit of the granted requester is released when its ack arrives.
  always_comb begin
    clr = '0;
    if (state == GRANT && ack) clr = NREQ'(1) << idx_q;
  end

  // Free-running timepulse slot counter, 0..11.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tp <= 4'd0;
    else if (tp == 4'd11) tp <= 4'd0;
    else tp <= tp + 4'd1;
  end

  // Edge detection, pending latches and sticky overrun; a new rise wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q   <= '0;
      pend    <= '0;
      overrun <= 1'b0;
    end else begin
      req_q <= req;
      pend  <= (pend & ~clr) | rise;
      if (|(rise & pend & ~clr)) overrun <= 1'b1;
    end
  end

  // Grant FSM with registered grant, done and timeout outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      idx_q     <= '0;
      cnt       <= '0;
      grant_vld <= 1'b0;
      grant_idx <= '0;
      done      <= '0;
      tmo_err   <= 1'b0;
    end else begin
      done    <= '0;
      tmo_err <= 1'b0;
      case (state)
        IDLE: begin
          if (tp == 4'd11 && !busy && |pend) begin
            state     <= GRANT;
            idx_q     <= win_idx;
            grant_idx <= win_idx;
            grant_vld <= 1'b1;
            cnt       <= '0;
          end
        end
        GRANT: begin
          if (ack) begin
            state     <= DONE;
            grant_vld <= 1'b0;
            grant_idx <= '0;
            done      <= NREQ'(1) << idx_q;
          end else if (cnt == 8'(TMO - 1)) begin
            state     <= IDLE;
            grant_vld <= 1'b0;
            grant_idx <= '0;
            tmo_err   <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_incr_priority_arbiter.sv
// Directed scoreboard bench for incr_priority_arbiter with default parameters.
module tb_incr_priority_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       busy;
  logic       ack;
  logic       grant_vld;
  logic [2:0] grant_idx;
  logic [7:0] done;
  logic [7:0] pend;
  logic [3:0] tp;
  logic       overrun;
  logic       tmo_err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  incr_priority_arbiter #(.NREQ(8), .IDXW(3), .TMO(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .busy      (busy),
    .ack       (ack),
    .grant_vld (grant_vld),
    .grant_idx (grant_idx),
    .done      (done),
    .pend      (pend),
    .tp        (tp),
    .overrun   (overrun),
    .tmo_err   (tmo_err)
  );

  // 10-unit clock period.
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] r, input logic b, input logic a);
    req  = r;
    busy = b;
    ack  = a;
  endtask

  task automatic expectVal(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("[TB] FAIL scoreboard_empty observed=0x%0h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic waitTp(input logic [3:0] v);
    int n = 0;
    while (tp !== v && n < 30) begin
      step();
      n++;
    end
    if (tp !== v) begin
      checks++;
      errors++;
      $error("[TB] FAIL wait_tp observed=0x%0h expected=0x%0h", tp, v);
    end
  endtask

  task automatic checkGrant(input string tag, input logic vld, input logic [2:0] idx);
    expectVal({tag, "_vld"}, 32'(vld));
    expectVal({tag, "_idx"}, 32'(idx));
    checkOutput(32'(grant_vld));
    checkOutput(32'(grant_idx));
  endtask

  task automatic checkDone(input string tag, input logic [7:0] d, input logic [7:0] p);
    expectVal({tag, "_done"}, 32'(d));
    expectVal({tag, "_pend"}, 32'(p));
    checkOutput(32'(done));
    checkOutput(32'(pend));
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(8'h00, 1'b0, 1'b0);
    repeat (3) step();

    // Reset state
    expectVal("rst_tp", 0);
    expectVal("rst_ovr", 0);
    expectVal("rst_tmo", 0);
    checkOutput(32'(tp));
    checkOutput(32'(overrun));
    checkOutput(32'(tmo_err));
    checkGrant("rst", 1'b0, 3'd0);
    checkDone("rst", 8'h00, 8'h00);
    rst = 1'b1;

    // Single request on index 5
    waitTp(4'd3);
    applyStimulus(8'h20, 1'b0, 1'b0);
    step();
    expectVal("single_pend", 32'h20);
    checkOutput(32'(pend));
    applyStimulus(8'h00, 1'b0, 1'b0);
    waitTp(4'd11);
    step();
    expectVal("single_tp0", 0);
    checkOutput(32'(tp));
    checkGrant("single_grant", 1'b1, 3'd5);
    step();
    step();
    applyStimulus(8'h00, 1'b0, 1'b1);
    step();
    checkGrant("single_donecyc", 1'b0, 3'd0);
    checkDone("single_done", 8'h20, 8'h00);
    applyStimulus(8'h00, 1'b0, 1'b0);
    step();
    checkDone("single_after", 8'h00, 8'h00);

    // ack while idle is ignored
    applyStimulus(8'h00, 1'b0, 1'b1);
    step();
    applyStimulus(8'h00, 1'b0, 1'b0);
    step();
    checkGrant("idle_ack", 1'b0, 3'd0);
    checkDone("idle_ack", 8'h00, 8'h00);

    // Priority between indices 2 and 6, one-cycle grant
    applyStimulus(8'h44, 1'b0, 1'b0);
    step();
    applyStimulus(8'h00, 1'b0, 1'b0);
    expectVal("prio_pend", 32'h44);
    checkOutput(32'(pend));
    waitTp(4'd11);
    step();
    checkGrant("prio_first", 1'b1, 3'd2);
    applyStimulus(8'h00, 1'b0, 1'b1);
    step();
    checkDone("prio_done2", 8'h04, 8'h40);
    applyStimulus(8'h00, 1'b0, 1'b0);
    waitTp(4'd11);
    step();
    checkGrant("prio_second", 1'b1, 3'd6);
    applyStimulus(8'h00, 1'b0, 1'b1);
    step();
    checkDone("prio_done6", 8'h40, 8'h00);
    applyStimulus(8'h00, 1'b0, 1'b0);
    step();

    // Busy blocks grants for three slots
    applyStimulus(8'h02, 1'b1, 1'b0);
    step();
    applyStimulus(8'h00, 1'b1, 1'b0);
    expectVal("busy_pend", 32'h02);
    checkOutput(32'(pend));
    for (int s = 0; s < 3; s++) begin
      waitTp(4'd11);
      step();
      checkGrant("busy_blocked", 1'b0, 3'd0);
    end
    waitTp(4'd7);
    applyStimulus(8'h00, 1'b0, 1'b0);
    waitTp(4'd11);
    step();
    checkGrant("busy_release", 1'b1, 3'd1);
    applyStimulus(8'h00, 1'b0, 1'b1);
    step();
    checkDone("busy_done", 8'h02, 8'h00);
    applyStimulus(8'h00, 1'b0, 1'b0);
    step();

    // Timeout on index 3, busy toggling must not disturb the grant
    applyStimulus(8'h08, 1'b0, 1'b0);
    step();
    applyStimulus(8'h00, 1'b0, 1'b0);
    waitTp(4'd11);
    step();
    checkGrant("tmo_grant", 1'b1, 3'd3);
    for (int k = 0; k < 11; k++) begin
      if (k == 4) busy = 1'b1;
      if (k == 6) busy = 1'b0;
      step();
      checkGrant("tmo_hold", 1'b1, 3'd3);
    end
    step();
    expectVal("tmo_pulse", 1);
    checkOutput(32'(tmo_err));
    checkGrant("tmo_drop", 1'b0, 3'd0);
    checkDone("tmo_keep", 8'h00, 8'h08);
    step();
    expectVal("tmo_single", 0);
    checkOutput(32'(tmo_err));
    waitTp(4'd11);
    step();
    checkGrant("tmo_regrant", 1'b1, 3'd3);
    applyStimulus(8'h00, 1'b0, 1'b1);
    step();
    checkDone("tmo_done", 8'h08, 8'h00);
    applyStimulus(8'h00, 1'b0, 1'b0);
    step();

    // New rise on index 0 during its DONE cycle
    applyStimulus(8'h01, 1'b0, 1'b0);
    step();
    applyStimulus(8'h00, 1'b0, 1'b0);
    waitTp(4'd11);
    step();
    checkGrant("coin_grant", 1'b1, 3'd0);
    applyStimulus(8'h00, 1'b0, 1'b1);
    step();
    checkDone("coin_donecyc", 8'h01, 8'h00);
    applyStimulus(8'h01, 1'b0, 1'b0);
    step();
    expectVal("coin_pend", 32'h01);
    expectVal("coin_ovr", 0);
    checkOutput(32'(pend));
    checkOutput(32'(overrun));

    // New rise on index 0 in the same cycle as its ack
    applyStimulus(8'h00, 1'b0, 1'b0);
    waitTp(4'd11);
    step();
    checkGrant("same_grant", 1'b1, 3'd0);
    applyStimulus(8'h01, 1'b0, 1'b1);
    step();
    checkDone("same_done", 8'h01, 8'h01);
    expectVal("same_ovr", 0);
    checkOutput(32'(overrun));
    applyStimulus(8'h00, 1'b0, 1'b0);
    waitTp(4'd11);
    step();
    applyStimulus(8'h00, 1'b0, 1'b1);
    step();
    checkDone("same_final", 8'h01, 8'h00);
    applyStimulus(8'h00, 1'b0, 1'b0);
    step();

    // Overrun on index 4
    applyStimulus(8'h10, 1'b0, 1'b0);
    step();
    applyStimulus(8'h00, 1'b0, 1'b0);
    step();
    expectVal("ovr_before", 0);
    checkOutput(32'(overrun));
    applyStimulus(8'h10, 1'b0, 1'b0);
    step();
    expectVal("ovr_set", 1);
    expectVal("ovr_pend", 32'h10);
    checkOutput(32'(overrun));
    checkOutput(32'(pend));
    applyStimulus(8'h00, 1'b0, 1'b0);
    waitTp(4'd11);
    step();
    checkGrant("ovr_grant", 1'b1, 3'd4);
    expectVal("ovr_held", 1);
    checkOutput(32'(overrun));

    // Asynchronous reset in the middle of the grant
    step();
    rst = 1'b0;
    req = 8'h80;
    #1;
    checkGrant("arst", 1'b0, 3'd0);
    checkDone("arst", 8'h00, 8'h00);
    expectVal("arst_tp", 0);
    expectVal("arst_ovr", 0);
    checkOutput(32'(tp));
    checkOutput(32'(overrun));
    step();
    rst = 1'b1;
    step();
    expectVal("rel_pend", 32'h80);
    expectVal("rel_tp", 1);
    checkOutput(32'(pend));
    checkOutput(32'(tp));
    step();
    expectVal("rel_pend_hold", 32'h80);
    checkOutput(32'(pend));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
